// File: rtl/switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | switch_pkg: shared types and helpers for the switch drain arbiter          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } sw_arb_state_e;

  // Port-id width; a single port still needs one bit to carry an id.
  function automatic int pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sw_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sw_sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head word is forced to zero while empty so the output never shows stale data.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | switch_drain_arbiter: round-robin burst drain of switch output ports into  |
// | one valid/ready stream tagged with the source port id.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module switch_drain_arbiter
  import switch_pkg::*;
#(
  parameter  int NUM_OF_PORTS = 4,
  parameter  int WORD_WIDTH   = 8,
  parameter  int BURST_MAX    = 8,
  parameter  int RD_LAT       = 1,
  parameter  int OUT_DEPTH    = 4,
  localparam int PID_W        = pid_w(NUM_OF_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arb_en,
  input  logic [NUM_OF_PORTS-1:0]          port_ready,
  input  logic                             read_out,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_OF_PORTS-1:0]          port_read,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH-1:0]            out_data,
  output logic [PID_W-1:0]                 out_port,
  output logic                             busy,
  output logic                             err_unexp
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  generate
    if (BURST_MAX < 1 || OUT_DEPTH < RD_LAT + 1) begin : g_param_check
      $error("switch_drain_arbiter: BURST_MAX must be >=1 and OUT_DEPTH >= RD_LAT+1");
    end
  endgenerate

  sw_arb_state_e     state;
  sw_arb_state_e     state_n;
  logic [PID_W-1:0]  rr_ptr;
  logic [PID_W-1:0]  grant;
  logic [PID_W-1:0]  grant_sel;
  logic [PID_W-1:0]  next_rr;
  logic [BW-1:0]     burst_cnt;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit;
  logic              issue;
  logic              grant_load;
  logic              rr_load;
  logic              ret_ok;
  logic              unexp;
  logic              ready_g;
  logic [WORD_WIDTH-1:0] port_data_g;

  // Lowest offset from ptr wins, so scan the offsets from the far end down.
  function automatic logic [PID_W-1:0] rr_pick(input logic [NUM_OF_PORTS-1:0] req,
                                               input logic [PID_W-1:0]        ptr);
    logic [PID_W-1:0] pick;
    logic [PID_W-1:0] j;
    pick = ptr;
    for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
      j = PID_W'((int'(ptr) + i) % NUM_OF_PORTS);
      if (req[j]) begin
        pick = j;
      end
    end
    return pick;
  endfunction

  assign grant_sel   = rr_pick(port_ready, rr_ptr);
  assign next_rr     = (grant == PID_W'(NUM_OF_PORTS - 1)) ? '0 : grant + PID_W'(1);
  assign ready_g     = port_ready[grant];
  assign port_data_g = port_out[grant*WORD_WIDTH +: WORD_WIDTH];
  // Words already in the FIFO plus words still returning must fit; pops add no credit.
  assign credit      = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(OUT_DEPTH);
  assign ret_ok      = read_out & (inflight != '0);
  assign unexp       = read_out & (inflight == '0);

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    port_read  = '0;
    grant_load = 1'b0;
    rr_load    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_en && (|port_ready)) begin
          state_n    = READ;
          grant_load = 1'b1;
        end
      end
      READ: begin
        issue            = arb_en & ready_g & credit & (burst_cnt < BW'(BURST_MAX));
        port_read[grant] = issue;
        if (!arb_en || !ready_g || (issue && (burst_cnt == BW'(BURST_MAX - 1)))) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if ((inflight == '0) || ((inflight == CW'(1)) && read_out)) begin
          state_n = IDLE;
          rr_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      inflight  <= '0;
      err_unexp <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_load) begin
        grant     <= grant_sel;
        burst_cnt <= '0;
      end else if (issue) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (rr_load) begin
        rr_ptr <= next_rr;
      end
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (unexp) begin
        err_unexp <= 1'b1;
      end
    end
  end

  sw_sync_fifo #(
    .WIDTH (PID_W + WORD_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_ok),
    .push_data ({grant, port_data_g}),
    .pop       (out_ready),
    .pop_data  ({out_port, out_data}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = (state != IDLE) | ~fifo_empty;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(ret_ok && fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_switch_drain_arbiter.sv
`default_nettype none
// Scoreboard bench for switch_drain_arbiter: a port model feeds words, expected
// reads and output words are queued by the stimulus and checked by a monitor.
module tb_switch_drain_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BMAX  = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           arb_en = 1'b0;
  logic [N-1:0]   port_ready = '0;
  logic           read_out = 1'b0;
  logic [N*W-1:0] port_out = '0;
  logic [N-1:0]   port_read;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_port;
  logic           busy;
  logic           err_unexp;

  switch_drain_arbiter #(
    .NUM_OF_PORTS (N),
    .WORD_WIDTH   (W),
    .BURST_MAX    (BMAX),
    .RD_LAT       (1),
    .OUT_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .port_ready (port_ready),
    .read_out   (read_out),
    .port_out   (port_out),
    .port_read  (port_read),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_port   (out_port),
    .busy       (busy),
    .err_unexp  (err_unexp)
  );

  always #5 clk = ~clk;

  logic [W-1:0] pq [N][$];
  int           exp_rd[$];
  logic [9:0]   exp_out[$];
  string        chk_name[$];
  logic [31:0]  chk_act[$];
  logic [31:0]  chk_exp[$];
  int           total = 0;
  int           bad = 0;
  int           read_cnt = 0;
  bit           rand_mode = 1'b0;
  int           inj_req = 0;
  int           inj_done = 0;
  logic [N-1:0] pr_s = '0;

  // Port model: one-cycle read latency, port_ready mirrors queue occupancy.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      port_ready = N'($urandom);
      read_out   = 1'($urandom);
      port_out   = (N*W)'($urandom);
    end else begin
      read_out = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pr_s[i] && pq[i].size() > 0) begin
          port_out[i*W +: W] = pq[i].pop_front();
          read_out = 1'b1;
        end
      end
      if (inj_req != inj_done) begin
        read_out = 1'b1;
        port_out = 32'hC3C3_C3C3;
        inj_done++;
      end
      for (int i = 0; i < N; i++) begin
        port_ready[i] = (pq[i].size() != 0);
      end
    end
  end

  // Monitor: sole owner of the comparison counters.
  int          m_e;
  logic [9:0]  m_w;
  string       m_n;
  logic [31:0] m_a;
  logic [31:0] m_x;
  always @(negedge clk) begin
    pr_s = port_read;
    if (port_read != '0) begin
      read_cnt++;
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL read_sel: port_read=%b but no read was expected", port_read);
      end else begin
        m_e = exp_rd.pop_front();
        if (port_read != N'(1 << m_e)) begin
          bad++;
          $display("FAIL read_sel: port_read=%b required %b", port_read, N'(1 << m_e));
        end
      end
    end
    if (out_valid && out_ready) begin
      total++;
      if (exp_out.size() == 0) begin
        bad++;
        $display("FAIL out_word: got port %0d data %h but no word was expected", out_port, out_data);
      end else begin
        m_w = exp_out.pop_front();
        if ({out_port, out_data} != m_w) begin
          bad++;
          $display("FAIL out_word: got port %0d data %h required port %0d data %h",
                   out_port, out_data, m_w[9:8], m_w[7:0]);
        end
      end
    end
    while (chk_name.size() > 0) begin
      m_n = chk_name.pop_front();
      m_a = chk_act.pop_front();
      m_x = chk_exp.pop_front();
      total++;
      if (m_a != m_x) begin
        bad++;
        $display("FAIL %s: got %0h required %0h", m_n, m_a, m_x);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic expect_word(input int p, input logic [7:0] d);
    exp_rd.push_back(p);
    exp_out.push_back({2'(p), d});
  endtask

  task automatic do_reset(input bit check);
    rst       = 1'b1;
    rand_mode = 1'b1;
    arb_en    = 1'($urandom);
    out_ready = 1'($urandom);
    tick();
    tick();
    if (check) begin
      chk("rst_port_read", 32'(port_read), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data), 0);
      chk("rst_out_port",  32'(out_port), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_err_unexp", 32'(err_unexp), 0);
    end
    rand_mode = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_rd.delete();
    exp_out.delete();
    arb_en    = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_rd.size() == 0 && exp_out.size() == 0 && !busy) break;
    end
    chk({name, "_reads_left"}, 32'(exp_rd.size()), 0);
    chk({name, "_words_left"}, 32'(exp_out.size()), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  int first_rd;
  int last_rd;
  int first_ov;
  int rd_run;
  int base;

  initial begin
    // 1: reset with random inputs
    do_reset(1'b1);

    // 2: single port, latency, then round-robin pointer moves past port 2
    arb_en    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pq[2].push_back(8'(8'hA0 + i));
      expect_word(2, 8'(8'hA0 + i));
    end
    first_rd = -1; last_rd = -1; first_ov = -1; rd_run = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (port_read == 4'b0100) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        rd_run++;
      end
      if (out_valid && first_ov < 0) first_ov = c;
    end
    chk("t2_read_cycles", 32'(rd_run), 3);
    chk("t2_read_span", 32'(last_rd - first_rd), 2);
    chk("t2_latency", 32'(first_ov - first_rd), 2);
    wait_drain("t2", 50);
    pq[0].push_back(8'h05);
    pq[3].push_back(8'h35);
    expect_word(3, 8'h35);
    expect_word(0, 8'h05);
    wait_drain("t2_rr", 50);

    // 3: all ports ready, full bursts in round-robin order
    do_reset(1'b0);
    arb_en = 1'b1;
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 9; i++) pq[p].push_back(8'((p << 4) | i));
    for (int p = 0; p < N; p++)
      for (int i = 0; i < BMAX; i++) expect_word(p, 8'((p << 4) | i));
    for (int p = 0; p < N; p++) expect_word(p, 8'((p << 4) | 8));
    wait_drain("t3", 300);

    // 4: backpressure limits reads to the FIFO depth, then resumes in order
    do_reset(1'b0);
    arb_en    = 1'b1;
    out_ready = 1'b0;
    base      = read_cnt;
    for (int i = 0; i < 20; i++) begin
      pq[1].push_back(8'(8'h40 + i));
      expect_word(1, 8'(8'h40 + i));
    end
    repeat (20) tick();
    chk("t4_stall_reads", 32'(read_cnt - base), DEPTH);
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold", {21'd0, out_valid, out_port, out_data}, {21'd0, 1'b1, 2'd1, 8'h40});
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t4", 300);
    chk("t4_total_reads", 32'(read_cnt - base), 20);

    // 5: arb_en drops after three reads
    do_reset(1'b0);
    arb_en = 1'b1;
    base   = read_cnt;
    for (int i = 0; i < 10; i++) pq[0].push_back(8'(8'h50 + i));
    for (int i = 0; i < 3; i++) expect_word(0, 8'(8'h50 + i));
    for (int c = 0; c < 30 && (read_cnt - base) < 3; c++) tick();
    arb_en = 1'b0;
    wait_drain("t5", 50);
    repeat (10) tick();
    chk("t5_reads", 32'(read_cnt - base), 3);
    chk("t5_idle_busy", 32'(busy), 0);

    // 6: unexpected return while idle
    do_reset(1'b0);
    inj_req++;
    tick();
    tick();
    chk("t6_err_set", 32'(err_unexp), 1);
    chk("t6_no_push", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    repeat (5) tick();
    chk("t6_err_held", 32'(err_unexp), 1);
    do_reset(1'b0);
    chk("t6_err_cleared", 32'(err_unexp), 0);

    for (int i = 0; i < 10 && chk_name.size() > 0; i++) tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
